// File: rtl/pn_switch_stage_pkg.sv
// ============================================================================
// Module      : pn_switch_stage_pkg
// Description : Shared widths, time constants and priority-mode encoding for
//               the permutation-network switch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pn_switch_stage_pkg;

  localparam int unsigned WIDTH_TIME = 8;
  localparam int unsigned WIDTH_FLIT = 32;

  // Empty slots (time 0) compete as the youngest possible flit.
  localparam logic [WIDTH_TIME-1:0] MAX_TIME = '1;

  typedef enum logic {
    MODE0 = 1'b0,
    MODE1 = 1'b1
  } mode_e;

  function automatic logic [WIDTH_TIME-1:0] age_of(input logic [WIDTH_TIME-1:0] t);
    return (t == '0) ? MAX_TIME : t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pn_switch_stage_arbiter.sv
// ============================================================================
// Module      : pn_switch_stage_arbiter
// Description : PN age arbiter. Decides whether a 2x2 stage crosses its flits
//               so the older flit reaches the port favoured by the current mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pn_switch_stage_arbiter
  import pn_switch_stage_pkg::*;
(
  input  logic [WIDTH_TIME-1:0] time0,
  input  logic [WIDTH_TIME-1:0] time1,
  input  logic                  mode,
  output logic                  swap
);

  logic [WIDTH_TIME-1:0] age0;
  logic [WIDTH_TIME-1:0] age1;

  assign age0 = age_of(time0);
  assign age1 = age_of(time1);

  // Mode 0 favours output 0, mode 1 favours output 1; ties never cross.
  assign swap = mode ? (age0 < age1) : (age1 < age0);

endmodule

`default_nettype wire

// File: rtl/pn_switch_stage.sv
// ============================================================================
// Module      : pn_switch_stage
// Description : Registered 2x2 permutation-network switch stage with tie-fair
//               priority mode and saturating swap/tie statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pn_switch_stage
  import pn_switch_stage_pkg::*;
#(
  parameter int unsigned FLIT_W    = WIDTH_FLIT,
  parameter int unsigned CNT_W     = 16,
  parameter logic        MODE_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [FLIT_W-1:0] flit_in0,
  input  logic [FLIT_W-1:0] flit_in1,
  output logic [FLIT_W-1:0] flit_out0,
  output logic [FLIT_W-1:0] flit_out1,
  output logic              swapped,
  output logic              mode_q,
  output logic [CNT_W-1:0]  swap_cnt,
  output logic [CNT_W-1:0]  tie_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH_TIME-1:0] t0;
  logic [WIDTH_TIME-1:0] t1;
  logic                  swap;
  logic                  tie;
  mode_e                 mode_state;
  mode_e                 mode_next;

  assign t0  = flit_in0[FLIT_W-1 -: WIDTH_TIME];
  assign t1  = flit_in1[FLIT_W-1 -: WIDTH_TIME];
  assign tie = (t0 != '0) && (t1 != '0) && (t0 == t1);

  pn_switch_stage_arbiter u_arbiter (
    .time0 (t0),
    .time1 (t1),
    .mode  (mode_q),
    .swap  (swap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_state <= mode_e'(MODE_INIT);
    end else begin
      mode_state <= mode_next;
    end
  end

  // Alternating the favoured port on every genuine tie keeps both inputs fair.
  always_comb begin
    mode_next = mode_state;
    if (en && tie) begin
      mode_next = (mode_state == MODE0) ? MODE1 : MODE0;
    end
  end

  assign mode_q = (mode_state == MODE1);

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_out0 <= '0;
      flit_out1 <= '0;
      swapped   <= 1'b0;
    end else if (en) begin
      flit_out0 <= swap ? flit_in1 : flit_in0;
      flit_out1 <= swap ? flit_in0 : flit_in1;
      swapped   <= swap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      swap_cnt <= '0;
      tie_cnt  <= '0;
    end else if (en) begin
      if (swap && (swap_cnt != '1)) begin
        swap_cnt <= swap_cnt + CNT_ONE;
      end
      if (tie && (tie_cnt != '1)) begin
        tie_cnt <= tie_cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire
